ddfs_cordic_pipe: RTL

//  Parametrised pipelined CORDIC direct digital frequency synthesiser: N-bit phase accumulator,
//  run-time FCW reload, phase offset, phase sync, valid-tagged pipeline. Emits quadrature
//  cos/sin samples at one per enabled clock; feeds DAC/mixer paths on the 100 MHz fabric clock.

---
 rtl/ddfs_cordic_pipe_pkg.sv | 77 +++++++
 rtl/ddfs_cordic_pipe_cordic_stage.sv | 51 +++++
 rtl/ddfs_cordic_pipe.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ddfs_cordic_pipe_pkg.sv
// ----------------------------------------------------------------------------
// ddfs_cordic_pipe_pkg
//   Shared constants and elaboration-time helpers for the CORDIC DDFS:
//   - quad_t      : encoding of the two phase MSBs (quadrant of the turn)
//   - atan_lut()  : micro-rotation angle atan(2^-i), scaled so 2^phase_w = 1 turn
//   - cordic_gain(): CORDIC gain K after a given number of micro-rotations
//   - x_init()    : start-vector magnitude round(amplitude / K)
//   No ports; imported by the top and the stage module.
// ----------------------------------------------------------------------------
package ddfs_cordic_pipe_pkg;

   typedef enum logic [1:0] {
      QUAD_0 = 2'b00,   // [  0, 90) deg
      QUAD_1 = 2'b01,   // [ 90,180) deg
      QUAD_2 = 2'b10,   // [180,270) deg
      QUAD_3 = 2'b11    // [270,360) deg
   } quad_t;

   // atan(2^-i) as a fraction of a full turn, scaled to 2^32.
   function automatic logic [31:0] atan32(input int i);
      case (i)
         0:  return 32'd536870912;
         1:  return 32'd316933406;
         2:  return 32'd167458907;
         3:  return 32'd85004756;
         4:  return 32'd42667331;
         5:  return 32'd21354465;
         6:  return 32'd10679838;
         7:  return 32'd5340245;
         8:  return 32'd2670163;
         9:  return 32'd1335087;
         10: return 32'd667544;
         11: return 32'd333772;
         12: return 32'd166886;
         13: return 32'd83443;
         14: return 32'd41722;
         15: return 32'd20861;
         16: return 32'd10430;
         17: return 32'd5215;
         18: return 32'd2608;
         19: return 32'd1304;
         20: return 32'd652;
         21: return 32'd326;
         22: return 32'd163;
         23: return 32'd81;
         24: return 32'd41;
         25: return 32'd20;
         26: return 32'd10;
         27: return 32'd5;
         28: return 32'd3;
         29: return 32'd1;
         30: return 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   // Round the 2^32-scaled table down to the CORDIC angle width.
   function automatic logic [31:0] atan_lut(input int i, input int phase_w);
      logic [32:0] v;
      if (phase_w >= 32) return atan32(i);
      v = {1'b0, atan32(i)} + (33'd1 << (31 - phase_w));
      return 32'(v >> (32 - phase_w));
   endfunction

   function automatic real cordic_gain(input int stages);
      real k;
      k = 1.0;
      for (int i = 0; i < stages; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
      return k;
   endfunction

   // Pre-scaling the start vector by 1/K makes the final magnitude = amplitude.
   function automatic int x_init(input int amplitude, input int stages);
      return $rtoi(amplitude / cordic_gain(stages) + 0.5);
   endfunction

endpackage

// File: rtl/ddfs_cordic_pipe_cordic_stage.sv
// ----------------------------------------------------------------------------
// cordic_stage
//   One registered CORDIC micro-rotation in rotation mode. Rotates (x,y) by
//   +/-atan(2^-SHIFT) towards driving the residual angle z to zero.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     x, y, z, vld    incoming vector, residual angle, sample-valid tag
//     x_q,y_q,z_q,vld_q  registered rotated vector, angle and tag
// ----------------------------------------------------------------------------
module cordic_stage
   import ddfs_cordic_pipe_pkg::*;
#(
   parameter int                    W       = 18,
   parameter int                    PHASE_W = 16,
   parameter int                    SHIFT   = 0,
   parameter logic [PHASE_W-1:0]    ATAN    = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [W-1:0]       x,
   input  logic signed [W-1:0]       y,
   input  logic        [PHASE_W-1:0] z,
   input  logic                      vld,
   output logic signed [W-1:0]       x_q,
   output logic signed [W-1:0]       y_q,
   output logic        [PHASE_W-1:0] z_q,
   output logic                      vld_q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q   <= '0;
         y_q   <= '0;
         z_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= vld;
         // Negative residual angle: rotate clockwise and add the angle back.
         if (z[PHASE_W-1]) begin
            x_q <= x + (y >>> SHIFT);
            y_q <= y - (x >>> SHIFT);
            z_q <= z + ATAN;
         end else begin
            x_q <= x - (y >>> SHIFT);
            y_q <= y + (x >>> SHIFT);
            z_q <= z - ATAN;
         end
      end
   end

endmodule

// File: rtl/ddfs_cordic_pipe.sv
// ----------------------------------------------------------------------------
// ddfs_cordic_pipe
//   Pipelined CORDIC direct digital frequency synthesiser. A phase
//   accumulator advanced by a run-time frequency control word feeds a
//   quadrant pre-rotation and STAGES CORDIC micro-rotations; cos/sin samples
//   leave a saturating output register STAGES+3 edges after issue.
//   Ports:
//     clock_100_MHz  clock (rising edge)
//     clear_DDFS     asynchronous active-high reset, flushes the pipeline
//     en             issue one sample and advance the accumulator
//     fcw_we/fcw_in  load a new frequency control word (phase continuous)
//     phase_off      phase offset added to the issued sample
//     phase_sync     issue this sample from phase 0
//     cos_out/sin_out signed quadrature samples, held while out_valid=0
//     out_valid      a new sample is present this cycle
// ----------------------------------------------------------------------------
module ddfs_cordic_pipe
   import ddfs_cordic_pipe_pkg::*;
#(
   parameter int ACC_W     = 32,
   parameter int PHASE_W   = 16,
   parameter int OUT_W     = 16,
   parameter int STAGES    = 16,
   parameter int AMPLITUDE = 20000
) (
   input  logic                     clock_100_MHz,
   input  logic                     clear_DDFS,
   input  logic                     en,
   input  logic                     fcw_we,
   input  logic [ACC_W-1:0]         fcw_in,
   input  logic [PHASE_W-1:0]       phase_off,
   input  logic                     phase_sync,
   output logic signed [OUT_W-1:0]  cos_out,
   output logic signed [OUT_W-1:0]  sin_out,
   output logic                     out_valid
);

   // Two guard bits absorb the CORDIC gain and rotation overshoot.
   localparam int W = OUT_W + 2;
   localparam logic signed [W-1:0]   X_INIT  = W'(x_init(AMPLITUDE, STAGES));
   localparam logic [PHASE_W-1:0]    QUARTER = {2'b01, {(PHASE_W-2){1'b0}}};
   localparam logic signed [W-1:0]   SAT_MAX = W'((1 << (OUT_W-1)) - 1);
   localparam logic signed [W-1:0]   SAT_MIN = -SAT_MAX - W'(1);

   function automatic logic signed [OUT_W-1:0] sat(input logic signed [W-1:0] v);
      if (v > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
      else if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
      else                  return v[OUT_W-1:0];
   endfunction

   logic [ACC_W-1:0]         fcw_q;
   logic [ACC_W-1:0]         acc;
   logic [ACC_W-1:0]         p_issue;
   logic [PHASE_W-1:0]       phase_p0;
   logic                     vld_p0;
   logic signed [W-1:0]      x_p1, y_p1;
   logic [PHASE_W-1:0]       z_p1;
   logic                     vld_p1;

   logic signed [W-1:0]      x_s   [STAGES+1];
   logic signed [W-1:0]      y_s   [STAGES+1];
   logic [PHASE_W-1:0]       z_s   [STAGES+1];
   logic                     vld_s [STAGES+1];

   // phase_sync only matters for an issued sample.
   always_comb begin
      p_issue = acc;
      if (phase_sync) p_issue = '0;
   end

   // ---- stage p0: FCW register, accumulator, offset adder ----
   always_ff @(posedge clock_100_MHz or posedge clear_DDFS) begin
      if (clear_DDFS) begin
         fcw_q    <= '0;
         acc      <= '0;
         phase_p0 <= '0;
         vld_p0   <= 1'b0;
      end else begin
         if (fcw_we) fcw_q <= fcw_in;
         if (en)     acc   <= p_issue + fcw_q;
         vld_p0   <= en;
         phase_p0 <= p_issue[ACC_W-1 -: PHASE_W] + phase_off;
      end
   end

   // ---- stage p1: quadrant pre-rotation into [-90,+90) deg ----
   always_ff @(posedge clock_100_MHz or posedge clear_DDFS) begin
      if (clear_DDFS) begin
         x_p1   <= '0;
         y_p1   <= '0;
         z_p1   <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         case (phase_p0[PHASE_W-1 -: 2])
            QUAD_1: begin
               x_p1 <= '0;
               y_p1 <= X_INIT;
               z_p1 <= phase_p0 - QUARTER;
            end
            QUAD_2: begin
               x_p1 <= '0;
               y_p1 <= -X_INIT;
               z_p1 <= phase_p0 + QUARTER;
            end
            default: begin
               x_p1 <= X_INIT;
               y_p1 <= '0;
               z_p1 <= phase_p0;
            end
         endcase
      end
   end

   assign x_s[0]   = x_p1;
   assign y_s[0]   = y_p1;
   assign z_s[0]   = z_p1;
   assign vld_s[0] = vld_p1;

   // ---- stages p2 .. p(STAGES+1): micro-rotations ----
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      cordic_stage #(
         .W       (W),
         .PHASE_W (PHASE_W),
         .SHIFT   (i),
         .ATAN    (PHASE_W'(atan_lut(i, PHASE_W)))
      ) u_stage (
         .clk   (clock_100_MHz),
         .rst   (clear_DDFS),
         .x     (x_s[i]),
         .y     (y_s[i]),
         .z     (z_s[i]),
         .vld   (vld_s[i]),
         .x_q   (x_s[i+1]),
         .y_q   (y_s[i+1]),
         .z_q   (z_s[i+1]),
         .vld_q (vld_s[i+1])
      );
   end

   // ---- output stage: saturation, hold while no new sample ----
   always_ff @(posedge clock_100_MHz or posedge clear_DDFS) begin
      if (clear_DDFS) begin
         cos_out   <= '0;
         sin_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= vld_s[STAGES];
         if (vld_s[STAGES]) begin
            cos_out <= sat(x_s[STAGES]);
            sin_out <= sat(y_s[STAGES]);
         end
      end
   end

endmodule
